// File: rtl/hub75_scanner.sv
// hub75_scanner: 1/32-scan timing generator for a 64x64 HUB75 panel.
// It asks the painter for colours, shifts them out, then latches and shows each row.
//
// Ports:
//   clk, reset       - system clock; asynchronous active-low reset
//   frame, subframe  - frame and subframe counters, sent to the painter
//   x, y             - coordinate being queried (y = {phase, row})
//   rgb              - painter colour {b,g,r} for the current x,y
//   hub_clk/lat/oe_n - panel shift clock, latch strobe, output enable (low = on)
//   hub_addr         - panel row address
//   hub_rgb0/1       - upper/lower half pixel data {b,g,r}

module hub75_scanner #(
    parameter int BLANK_CYCLES   = 2,
    parameter int DISPLAY_CYCLES = 64,
    parameter int SUBFRAMES      = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic [12:0] frame,
    output logic [7:0]  subframe,
    output logic [5:0]  x,
    output logic [5:0]  y,
    input  logic [2:0]  rgb,
    output logic        hub_clk,
    output logic        hub_lat,
    output logic        hub_oe_n,
    output logic [4:0]  hub_addr,
    output logic [2:0]  hub_rgb0,
    output logic [2:0]  hub_rgb1
);

    localparam logic [15:0] BLANK_LOAD   = 16'(BLANK_CYCLES - 1);
    localparam logic [15:0] DISPLAY_LOAD = 16'(DISPLAY_CYCLES - 1);
    localparam logic [7:0]  SUB_LAST     = 8'(SUBFRAMES - 1);

    typedef enum logic [2:0] {
        SHIFT,
        TAIL,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    state_t      state;
    logic [5:0]  col;
    logic [4:0]  row;
    logic        phase;
    logic [15:0] cnt;
    logic [2:0]  upper;

    logic        row_done;
    logic        sub_wrap;
    logic [12:0] frame_nxt;

    // Column and phase freeze at 63/1 once shifting ends, so the painter
    // sees x=63, y={1,row} until the next row begins.
    assign x = col;
    assign y = {phase, row};

    assign row_done  = (state == DISPLAY) && (cnt == 16'd0);
    assign sub_wrap  = row_done && (row == 5'd31) && (subframe == SUB_LAST);
    assign frame_nxt = sub_wrap ? frame + 13'd1 : frame;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= SHIFT;
            frame    <= 13'd0;
            subframe <= 8'd0;
            col      <= 6'd0;
            row      <= 5'd0;
            phase    <= 1'b0;
            cnt      <= 16'd0;
            upper    <= 3'd0;
            hub_clk  <= 1'b0;
            hub_lat  <= 1'b0;
            hub_oe_n <= 1'b1;
            hub_addr <= 5'd0;
            hub_rgb0 <= 3'd0;
            hub_rgb1 <= 3'd0;
        end else begin
            // Written every cycle so the counter always reloads from its
            // own current value, even in cycles where it does not advance.
            frame <= frame_nxt;
            unique case (state)
                SHIFT: begin
                    if (!phase) begin
                        // Rising edge here clocks the column presented
                        // on the previous phase-1 cycle.
                        upper   <= rgb;
                        hub_clk <= (col != 6'd0);
                        phase   <= 1'b1;
                    end else begin
                        hub_rgb0 <= upper;
                        hub_rgb1 <= rgb;
                        hub_clk  <= 1'b0;
                        if (col == 6'd63) begin
                            state <= TAIL;
                        end else begin
                            col   <= col + 6'd1;
                            phase <= 1'b0;
                        end
                    end
                end
                TAIL: begin
                    hub_clk <= 1'b1;
                    cnt     <= BLANK_LOAD;
                    state   <= BLANK;
                end
                BLANK: begin
                    hub_clk  <= 1'b0;
                    hub_oe_n <= 1'b1;
                    if (cnt == 16'd0) begin
                        state <= LATCH;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                LATCH: begin
                    hub_lat  <= 1'b1;
                    hub_addr <= row;
                    cnt      <= DISPLAY_LOAD;
                    state    <= DISPLAY;
                end
                DISPLAY: begin
                    hub_lat  <= 1'b0;
                    hub_oe_n <= 1'b0;
                    if (cnt == 16'd0) begin
                        row   <= row + 5'd1;
                        col   <= 6'd0;
                        phase <= 1'b0;
                        state <= SHIFT;
                        if (row == 5'd31) begin
                            subframe <= (subframe == SUB_LAST) ?
                                        8'd0 : subframe + 8'd1;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= SHIFT;
            endcase
        end
    end

endmodule
